// File: rtl/rps_match_controller_pkg.sv
// Shared move/verdict codes, FSM state encoding and helpers for the
// rock-paper-scissors match controller and its referee.
package rps_match_controller_pkg;

    localparam int unsigned MOVE_W  = 2;
    localparam int unsigned SCORE_W = 3;
    localparam int unsigned LFSR_W  = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(7);

    typedef enum logic [MOVE_W-1:0] {
        STONE    = 2'b00,
        PAPER    = 2'b01,
        SCISSORS = 2'b10,
        INVALID  = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        TIE    = 2'b00,
        P1_WIN = 2'b01,
        P2_WIN = 2'b10,
        BAD    = 2'b11
    } verdict_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_MOVE = 3'd1,
        ISSUE     = 3'd2,
        WAIT_RES  = 3'd3,
        SCORE     = 3'd4,
        DONE      = 3'd5
    } state_t;

    typedef struct packed {
        move_t p1;
        move_t p2;
    } round_moves_t;

    // Folds the 11 code back onto a legal move so the machine never plays INVALID.
    function automatic move_t machine_move(input logic [LFSR_W-1:0] s);
        if (s[1:0] == 2'b11) begin
            return move_t'({1'b0, s[2]});
        end
        return move_t'(s[1:0]);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/rps_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying the machine's move.
module rps_lfsr8
    import rps_match_controller_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (ena) begin
            state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
        end
    end

endmodule

// File: rtl/rps_match_controller.sv
// Best-of-N rock-paper-scissors match sequencer: captures moves, drives the
// referee handshake, keeps score and declares the match winner.
module rps_match_controller
    import rps_match_controller_pkg::*;
#(
    parameter int unsigned       WIN_TARGET = 2,
    parameter int unsigned       RES_LAT    = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               go,
    input  logic [MOVE_W-1:0]  human_move,
    input  logic               human_valid,
    output logic [MOVE_W-1:0]  p1_move,
    output logic [MOVE_W-1:0]  p2_move,
    output logic               round_start,
    input  logic [1:0]         winner_in,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic               busy
);

    localparam int unsigned        CNT_W    = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RES_LAT - 1);
    localparam logic [SCORE_W-1:0] TARGET   = SCORE_W'(WIN_TARGET);

    state_t              state;
    logic                run_q;
    logic                step;
    logic [CNT_W-1:0]    lat_cnt;
    verdict_t            verdict_q;
    round_moves_t        moves_q;
    logic [LFSR_W-1:0]   lfsr;
    logic [SCORE_W-1:0]  s1_nxt;
    logic [SCORE_W-1:0]  s2_nxt;

    // Reset release is registered once so nothing moves on the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign step = ena && run_q;

    rps_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (step),
        .state (lfsr)
    );

    always_comb begin
        s1_nxt = score_p1;
        s2_nxt = score_p2;
        case (verdict_q)
            P1_WIN:  s1_nxt = sat_inc(score_p1);
            P2_WIN:  s2_nxt = sat_inc(score_p2);
            default: ;
        endcase
    end

    assign p1_move = moves_q.p1;
    assign p2_move = moves_q.p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            verdict_q    <= TIE;
            moves_q      <= '0;
            round_start  <= 1'b0;
            score_p1     <= '0;
            score_p2     <= '0;
            match_over   <= 1'b0;
            match_winner <= 2'b00;
            busy         <= 1'b0;
        end else if (step) begin
            round_start <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state        <= WAIT_MOVE;
                        score_p1     <= '0;
                        score_p2     <= '0;
                        match_over   <= 1'b0;
                        match_winner <= 2'b00;
                        busy         <= 1'b1;
                    end
                end
                WAIT_MOVE: begin
                    if (human_valid) begin
                        moves_q.p1  <= move_t'(human_move);
                        moves_q.p2  <= machine_move(lfsr);
                        round_start <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= '0;
                    state   <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (lat_cnt == CNT_LAST) begin
                        verdict_q <= verdict_t'(winner_in);
                        state     <= SCORE;
                    end else begin
                        lat_cnt <= lat_cnt + CNT_W'(1);
                    end
                end
                SCORE: begin
                    score_p1 <= s1_nxt;
                    score_p2 <= s2_nxt;
                    if (s1_nxt >= TARGET) begin
                        match_over   <= 1'b1;
                        match_winner <= P1_WIN;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else if (s2_nxt >= TARGET) begin
                        match_over   <= 1'b1;
                        match_winner <= P2_WIN;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else begin
                        state <= WAIT_MOVE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rps_match_controller.sv
// Directed bench for rps_match_controller with a scripted referee and an
// independent model of the machine-move LFSR.
module tb_rps_match_controller;
    import rps_match_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       go;
    logic [1:0] human_move;
    logic       human_valid;
    logic [1:0] p1_move;
    logic [1:0] p2_move;
    logic       round_start;
    logic [1:0] winner_in;
    logic [2:0] score_p1;
    logic [2:0] score_p2;
    logic       match_over;
    logic [1:0] match_winner;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int rs_cnt   = 0;
    int rs_base  = 0;

    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] m_prev = 8'hA5;
    bit         m_run  = 1'b0;

    rps_match_controller #(
        .WIN_TARGET (2),
        .RES_LAT    (2),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .go           (go),
        .human_move   (human_move),
        .human_valid  (human_valid),
        .p1_move      (p1_move),
        .p2_move      (p2_move),
        .round_start  (round_start),
        .winner_in    (winner_in),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .match_over   (match_over),
        .match_winner (match_winner),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [1:0] mm(input logic [7:0] s);
        logic [1:0] m;
        m = s[1:0];
        if (m == 2'b11) m = {1'b0, s[2]};
        return m;
    endfunction

    // Machine-move model: advances on every enabled edge from the second edge after reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_lfsr = 8'hA5;
            m_prev = 8'hA5;
            m_run  = 1'b0;
        end else begin
            m_prev = m_lfsr;
            if (m_run && ena) m_lfsr = lfsr_step(m_lfsr);
            m_run = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (round_start === 1'b1) rs_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_p1_move"}, p1_move, 0);
        chk({tag, "_p2_move"}, p2_move, 0);
        chk({tag, "_round_start"}, round_start, 0);
        chk({tag, "_score_p1"}, score_p1, 0);
        chk({tag, "_score_p2"}, score_p2, 0);
        chk({tag, "_match_over"}, match_over, 0);
        chk({tag, "_match_winner"}, match_winner, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Release reset with go held: the first edge must be ignored, the second starts the match.
    task automatic release_and_start();
        rst_n = 1'b1;
        go    = 1'b1;
        tick();
        chk("first_edge_after_release_busy", busy, 0);
        tick();
        go = 1'b0;
        chk("second_edge_after_release_busy", busy, 1);
        chk("fresh_score_p1", score_p1, 0);
        chk("fresh_score_p2", score_p2, 0);
    endtask

    task automatic start_match();
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_busy", busy, 1);
        chk("go_score_p1", score_p1, 0);
        chk("go_score_p2", score_p2, 0);
        chk("go_match_over", match_over, 0);
        chk("go_match_winner", match_winner, 0);
    endtask

    // One round; the referee presents the verdict only in the cycle it must be sampled.
    task automatic play_round(input logic [1:0] mv, input logic [1:0] vd, input int hold,
                              input bit pause, input bit go_mid,
                              input logic [2:0] e1, input logic [2:0] e2,
                              input logic eo, input logic [1:0] ew, input logic eb);
        logic [1:0] exp_p2;
        human_move  = mv;
        human_valid = 1'b1;
        winner_in   = BAD;
        tick();
        exp_p2 = mm(m_prev);
        chk("round_start_in_issue", round_start, 1);
        chk("p1_capture", p1_move, mv);
        chk("p2_lfsr_move", p2_move, exp_p2);
        chk("p2_never_invalid", {7'd0, p2_move == 2'b11}, 0);
        for (int e = 2; e <= 5; e++) begin
            human_valid = (e <= hold);
            winner_in   = (e == 4) ? vd : BAD;
            if (e == 3 && pause) begin
                ena = 1'b0;
                repeat (10) tick();
                chk("pause_busy", busy, 1);
                chk("pause_round_start", round_start, 0);
                chk("pause_score_p1", score_p1, e1 == 3'd0 ? 3'd0 : score_p1);
                ena = 1'b1;
            end
            if (e == 3 && go_mid) go = 1'b1;
            tick();
            go = 1'b0;
            if (e == 2) chk("round_start_one_cycle", round_start, 0);
            if (e == 4) begin
                chk("p1_stable_in_score", p1_move, mv);
                chk("p2_stable_in_score", p2_move, exp_p2);
            end
        end
        human_valid = 1'b0;
        winner_in   = TIE;
        chk("round_score_p1", score_p1, e1);
        chk("round_score_p2", score_p2, e2);
        chk("round_match_over", match_over, eo);
        chk("round_match_winner", match_winner, ew);
        chk("round_busy", busy, eb);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; go = 1'b0;
        human_move = STONE; human_valid = 1'b0; winner_in = TIE;
        repeat (3) tick();
        chk_idle_outputs("reset");

        release_and_start();

        // Human stone, referee always P1.
        play_round(STONE, P1_WIN, 1, 0, 0, 3'd1, 3'd0, 1'b0, 2'b00, 1'b1);
        play_round(STONE, P1_WIN, 1, 0, 0, 3'd2, 3'd0, 1'b1, 2'b01, 1'b0);

        // Restart from DONE; ties and invalid verdicts replay the round.
        start_match();
        rs_base = rs_cnt;
        play_round(PAPER, TIE,    1, 0, 0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b1);
        play_round(PAPER, BAD,    1, 0, 0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b1);
        play_round(STONE, P2_WIN, 1, 0, 0, 3'd0, 3'd1, 1'b0, 2'b00, 1'b1);
        play_round(STONE, P2_WIN, 1, 0, 0, 3'd0, 3'd2, 1'b1, 2'b10, 1'b0);
        chk("four_round_starts", 8'(rs_cnt - rs_base), 4);

        // go during WAIT_RES has no effect; held human_valid captures once.
        start_match();
        play_round(SCISSORS, P1_WIN, 1, 0, 1, 3'd1, 3'd0, 1'b0, 2'b00, 1'b1);
        rs_base = rs_cnt;
        play_round(PAPER, P2_WIN, 5, 0, 0, 3'd1, 3'd1, 1'b0, 2'b00, 1'b1);
        repeat (2) tick();
        chk("held_valid_single_start", 8'(rs_cnt - rs_base), 1);
        chk("held_valid_busy", busy, 1);

        // Enable dropped for 10 cycles inside WAIT_RES.
        play_round(STONE, TIE, 1, 1, 0, 3'd1, 3'd1, 1'b0, 2'b00, 1'b1);
        play_round(SCISSORS, P2_WIN, 1, 1, 0, 3'd1, 3'd2, 1'b1, 2'b10, 1'b0);

        // Long run of replayed rounds exercising the machine move.
        start_match();
        for (int i = 0; i < 1000; i++) begin
            play_round(move_t'(2'(i % 3)), TIE, 1, 0, 0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b1);
        end
        play_round(STONE, P1_WIN, 1, 0, 0, 3'd1, 3'd0, 1'b0, 2'b00, 1'b1);

        // Asynchronous reset during ISSUE abandons the round.
        human_move  = PAPER;
        human_valid = 1'b1;
        tick();
        human_valid = 1'b0;
        chk("issue_before_reset", round_start, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        repeat (2) tick();
        chk("reset_no_residual_start", round_start, 0);
        release_and_start();
        play_round(STONE, P2_WIN, 1, 0, 0, 3'd0, 3'd1, 1'b0, 2'b00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
